// File: rtl/wb_regfile_if.sv
// wb_regfile_if: W-stage writeback inputs, decode read ports and debug outputs
// of the writeback/register-file block.
interface wb_regfile_if #(parameter int WIDTH = 32);
    logic             regwriteW;
    logic [1:0]       resultsrcW;
    logic [WIDTH-1:0] readdataW;
    logic [WIDTH-1:0] aluresultW;
    logic [4:0]       rdW;
    logic [WIDTH-1:0] pcplus4W;
    logic [WIDTH-1:0] immextW;
    logic [4:0]       rs1D;
    logic [4:0]       rs2D;
    logic [WIDTH-1:0] rd1D;
    logic [WIDTH-1:0] rd2D;
    logic [WIDTH-1:0] resultW;
    logic [WIDTH-1:0] a0;
    logic [31:0]      commitcnt;

    modport master (
        output regwriteW, resultsrcW, readdataW, aluresultW, rdW, pcplus4W, immextW, rs1D, rs2D,
        input  rd1D, rd2D, resultW, a0, commitcnt
    );
    modport slave (
        input  regwriteW, resultsrcW, readdataW, aluresultW, rdW, pcplus4W, immextW, rs1D, rs2D,
        output rd1D, rd2D, resultW, a0, commitcnt
    );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: writeback result select plus 32-entry register file with
// same-cycle write-to-read bypass, a0 mirror and commit counter.
module wb_regfile #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32
) (
    input logic         clk,
    input logic         rst,
    wb_regfile_if.slave bus
);
    logic [WIDTH-1:0] regs [NREG];
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] a0_q;
    logic [31:0]      cnt;
    logic             commit;

    assign res = bus.resultsrcW == 2'b00 ? bus.aluresultW :
                 bus.resultsrcW == 2'b01 ? bus.readdataW  :
                 bus.resultsrcW == 2'b10 ? bus.pcplus4W   : bus.immextW;
    // reset suppresses both the write and the bypass path
    assign commit = bus.regwriteW && bus.rdW != 5'd0 && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            a0_q <= '0;
            cnt  <= '0;
        end else if (commit) begin
            regs[bus.rdW] <= res;
            if (bus.rdW == 5'd10) a0_q <= res;
            cnt <= cnt + 32'd1;
        end
    end

    assign bus.rd1D      = bus.rs1D == 5'd0 ? '0 : commit && bus.rs1D == bus.rdW ? res : regs[bus.rs1D];
    assign bus.rd2D      = bus.rs2D == 5'd0 ? '0 : commit && bus.rs2D == bus.rdW ? res : regs[bus.rs2D];
    assign bus.resultW   = res;
    assign bus.a0        = a0_q;
    assign bus.commitcnt = cnt;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed vector table for mux/commit/bypass/a0/counter,
// plus hand-written reset, wrap and mid-run reset sequences.
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

    wb_regfile_if #(.WIDTH(32)) bus ();
    wb_regfile #(.WIDTH(32), .NREG(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [1:0]  src;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] e_res;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic [31:0] e_a0;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rw, input logic [1:0] src, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [4:0] rs1, input logic [4:0] rs2);
        bus.regwriteW  = rw;
        bus.resultsrcW = src;
        bus.rdW        = rd;
        bus.aluresultW = alu;
        bus.rs1D       = rs1;
        bus.rs2D       = rs2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // fixed sources for the non-ALU mux legs
        bus.readdataW = 32'h22;
        bus.pcplus4W  = 32'h33;
        bus.immextW   = 32'h44;

        // rw src rd alu rs1 rs2 | result rd1 rd2 | a0 cnt after edge
        vecs[0]  = '{1'b1, 2'd0, 5'd1,  32'h11,       5'd1,  5'd0,  32'h11,       32'h11,  32'h0,   32'h0,  32'd1};
        vecs[1]  = '{1'b1, 2'd1, 5'd2,  32'h11,       5'd1,  5'd2,  32'h22,       32'h11,  32'h22,  32'h0,  32'd2};
        vecs[2]  = '{1'b1, 2'd2, 5'd3,  32'h11,       5'd2,  5'd3,  32'h33,       32'h22,  32'h33,  32'h0,  32'd3};
        vecs[3]  = '{1'b1, 2'd3, 5'd4,  32'h11,       5'd3,  5'd4,  32'h44,       32'h33,  32'h44,  32'h0,  32'd4};
        vecs[4]  = '{1'b0, 2'd0, 5'd4,  32'h11,       5'd1,  5'd4,  32'h11,       32'h11,  32'h44,  32'h0,  32'd4};
        vecs[5]  = '{1'b1, 2'd0, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'hFFFFFFFF, 32'h0,   32'h0,   32'h0,  32'd4};
        vecs[6]  = '{1'b1, 2'd0, 5'd7,  32'h100,      5'd1,  5'd2,  32'h100,      32'h11,  32'h22,  32'h0,  32'd5};
        vecs[7]  = '{1'b1, 2'd0, 5'd7,  32'h200,      5'd7,  5'd7,  32'h200,      32'h200, 32'h200, 32'h0,  32'd6};
        vecs[8]  = '{1'b0, 2'd0, 5'd7,  32'h300,      5'd7,  5'd7,  32'h300,      32'h200, 32'h200, 32'h0,  32'd6};
        vecs[9]  = '{1'b1, 2'd0, 5'd7,  32'h100,      5'd7,  5'd0,  32'h100,      32'h100, 32'h0,   32'h0,  32'd7};
        vecs[10] = '{1'b0, 2'd0, 5'd7,  32'h200,      5'd7,  5'd7,  32'h200,      32'h100, 32'h100, 32'h0,  32'd7};
        vecs[11] = '{1'b1, 2'd0, 5'd10, 32'h2A,       5'd10, 5'd0,  32'h2A,       32'h2A,  32'h0,   32'h2A, 32'd8};
        vecs[12] = '{1'b1, 2'd0, 5'd11, 32'h55,       5'd10, 5'd11, 32'h55,       32'h2A,  32'h55,  32'h2A, 32'd9};

        // reset held two cycles with a pending write to x5
        rst = 1'b1;
        drive(1'b1, 2'd0, 5'd5, 32'hDEAD, 5'd5, 5'd0);
        tick;
        chk("rst_no_bypass", bus.rd1D, 32'h0);
        tick;
        rst = 1'b0;
        drive(1'b0, 2'd0, 5'd5, 32'hDEAD, 5'd5, 5'd0);
        #1;
        chk("rst_x5", bus.rd1D, 32'h0);
        chk("rst_a0", bus.a0, 32'h0);
        chk("rst_cnt", bus.commitcnt, 32'h0);

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].rw, vecs[i].src, vecs[i].rd, vecs[i].alu, vecs[i].rs1, vecs[i].rs2);
            #1;
            chk($sformatf("v%0d_result", i), bus.resultW, vecs[i].e_res);
            chk($sformatf("v%0d_rd1", i), bus.rd1D, vecs[i].e_rd1);
            chk($sformatf("v%0d_rd2", i), bus.rd2D, vecs[i].e_rd2);
            tick;
            chk($sformatf("v%0d_a0", i), bus.a0, vecs[i].e_a0);
            chk($sformatf("v%0d_cnt", i), bus.commitcnt, vecs[i].e_cnt);
        end

        // counter wrap from a preloaded all-ones value
        drive(1'b0, 2'd0, 5'd0, 32'h0, 5'd0, 5'd0);
        #1;
        force dut.cnt = 32'hFFFFFFFF;
        #1;
        release dut.cnt;
        #1;
        chk("preload_cnt", bus.commitcnt, 32'hFFFFFFFF);
        drive(1'b1, 2'd0, 5'd12, 32'h9, 5'd12, 5'd0);
        tick;
        chk("wrap_cnt", bus.commitcnt, 32'h0);
        drive(1'b0, 2'd0, 5'd0, 32'h0, 5'd12, 5'd3);
        #1;
        chk("wrap_x12", bus.rd1D, 32'h9);
        chk("pre_rst_x3", bus.rd2D, 32'h33);

        // reset coinciding with a commit to x3: write dropped, no bypass
        rst = 1'b1;
        drive(1'b1, 2'd0, 5'd3, 32'h77, 5'd3, 5'd10);
        #1;
        chk("midrst_no_bypass", bus.rd1D, 32'h33);
        tick;
        rst = 1'b0;
        drive(1'b0, 2'd0, 5'd3, 32'h77, 5'd3, 5'd10);
        #1;
        chk("midrst_x3", bus.rd1D, 32'h0);
        chk("midrst_x10", bus.rd2D, 32'h0);
        chk("midrst_a0", bus.a0, 32'h0);
        chk("midrst_cnt", bus.commitcnt, 32'h0);
        tick;
        chk("midrst_x3_held", bus.rd1D, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
